// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the 2-wide fetch-to-decode instruction buffer.
package inst_buffer_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned FLAGS_W = 6;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned ENTRY_W = INST_W + FLAGS_W + PC_W;

  // Slot1 always sits one instruction after slot0.
  localparam logic [PC_W-1:0] PC_INC = 32'h4;

  typedef struct packed {
    logic [INST_W-1:0]  inst;
    logic [FLAGS_W-1:0] flags;
    logic [PC_W-1:0]    pc;
  } entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/decode side bundle of the instruction buffer; slave = buffer, master = environment.
interface inst_buffer_if #(parameter int unsigned P_DEPTH_N = 4);
  import inst_buffer_pkg::*;

  logic                 iEXCEPTION_EVENT;
  logic                 iEXCEPTION_INST_DISCARD;
  logic                 iPREVIOUS_0_INST_VALID;
  logic [FLAGS_W-1:0]   iPREVIOUS_0_MMU_FLAGS;
  logic [INST_W-1:0]    iPREVIOUS_0_INST;
  logic                 iPREVIOUS_1_INST_VALID;
  logic [FLAGS_W-1:0]   iPREVIOUS_1_MMU_FLAGS;
  logic [INST_W-1:0]    iPREVIOUS_1_INST;
  logic [PC_W-1:0]      iPREVIOUS_PC;
  logic                 oPREVIOUS_LOCK;
  logic                 oNEXT_0_INST_VALID;
  logic [FLAGS_W-1:0]   oNEXT_0_MMU_FLAGS;
  logic [INST_W-1:0]    oNEXT_0_INST;
  logic [PC_W-1:0]      oNEXT_0_PC;
  logic                 oNEXT_1_INST_VALID;
  logic [FLAGS_W-1:0]   oNEXT_1_MMU_FLAGS;
  logic [INST_W-1:0]    oNEXT_1_INST;
  logic [PC_W-1:0]      oNEXT_1_PC;
  logic                 iNEXT_LOCK;
  logic [P_DEPTH_N:0]   oCOUNT;

  modport slave (
    input  iEXCEPTION_EVENT, iEXCEPTION_INST_DISCARD,
           iPREVIOUS_0_INST_VALID, iPREVIOUS_0_MMU_FLAGS, iPREVIOUS_0_INST,
           iPREVIOUS_1_INST_VALID, iPREVIOUS_1_MMU_FLAGS, iPREVIOUS_1_INST,
           iPREVIOUS_PC, iNEXT_LOCK,
    output oPREVIOUS_LOCK,
           oNEXT_0_INST_VALID, oNEXT_0_MMU_FLAGS, oNEXT_0_INST, oNEXT_0_PC,
           oNEXT_1_INST_VALID, oNEXT_1_MMU_FLAGS, oNEXT_1_INST, oNEXT_1_PC,
           oCOUNT
  );

  modport master (
    output iEXCEPTION_EVENT, iEXCEPTION_INST_DISCARD,
           iPREVIOUS_0_INST_VALID, iPREVIOUS_0_MMU_FLAGS, iPREVIOUS_0_INST,
           iPREVIOUS_1_INST_VALID, iPREVIOUS_1_MMU_FLAGS, iPREVIOUS_1_INST,
           iPREVIOUS_PC, iNEXT_LOCK,
    input  oPREVIOUS_LOCK,
           oNEXT_0_INST_VALID, oNEXT_0_MMU_FLAGS, oNEXT_0_INST, oNEXT_0_PC,
           oNEXT_1_INST_VALID, oNEXT_1_MMU_FLAGS, oNEXT_1_INST, oNEXT_1_PC,
           oCOUNT
  );

endinterface

// File: rtl/inst_buffer_ram.sv
// Entry storage: two write ports on adjacent addresses, two asynchronous read ports.
module inst_buffer_ram
  import inst_buffer_pkg::*;
#(
  parameter int unsigned P_DEPTH   = 16,
  parameter int unsigned P_DEPTH_N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we0,
  input  logic [P_DEPTH_N-1:0] waddr0,
  input  entry_t               wdata0,
  input  logic                 we1,
  input  logic [P_DEPTH_N-1:0] waddr1,
  input  entry_t               wdata1,
  input  logic [P_DEPTH_N-1:0] raddr0,
  output entry_t               rdata0,
  input  logic [P_DEPTH_N-1:0] raddr1,
  output entry_t               rdata1
);

  logic [ENTRY_W-1:0] mem [P_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < P_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = entry_t'(mem[raddr0]);
  assign rdata1 = entry_t'(mem[raddr1]);

endmodule

// File: rtl/inst_buffer.sv
// 2-wide instruction queue between fetch and decode; flushed whole on an exception event.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned P_DEPTH   = 16,
  parameter int unsigned P_DEPTH_N = 4
) (
  input  logic         iCLOCK,
  input  logic         inRESET,
  inst_buffer_if.slave bus
);

  localparam int unsigned          CNT_W      = P_DEPTH_N + 1;
  localparam logic [CNT_W-1:0]     LOCK_LEVEL = CNT_W'(P_DEPTH - 1);

  logic [P_DEPTH_N-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [1:0]           wr_amt, rd_amt;
  logic                 lock, show0, show1;
  entry_t               wdata0, wdata1, rdata0, rdata1;

  // State register: pointers and occupancy.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Lock only looks at registered occupancy, so a same-cycle read never frees room.
  always_comb begin
    lock   = (count >= LOCK_LEVEL);
    show0  = (count != '0) && !bus.iNEXT_LOCK && !bus.iEXCEPTION_EVENT;
    show1  = (count >= CNT_W'(2)) && !bus.iNEXT_LOCK && !bus.iEXCEPTION_EVENT;
    rd_amt = {1'b0, show0} + {1'b0, show1};
    wr_amt = 2'd0;
    if (!lock && !bus.iEXCEPTION_EVENT && !bus.iEXCEPTION_INST_DISCARD &&
        bus.iPREVIOUS_0_INST_VALID) begin
      wr_amt = bus.iPREVIOUS_1_INST_VALID ? 2'd2 : 2'd1;
    end

    wdata0 = '{inst: bus.iPREVIOUS_0_INST, flags: bus.iPREVIOUS_0_MMU_FLAGS,
               pc: bus.iPREVIOUS_PC};
    wdata1 = '{inst: bus.iPREVIOUS_1_INST, flags: bus.iPREVIOUS_1_MMU_FLAGS,
               pc: bus.iPREVIOUS_PC + PC_INC};

    wr_ptr_nxt = wr_ptr + P_DEPTH_N'(wr_amt);
    rd_ptr_nxt = rd_ptr + P_DEPTH_N'(rd_amt);
    count_nxt  = count + CNT_W'(wr_amt) - CNT_W'(rd_amt);
    if (bus.iEXCEPTION_EVENT) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end
  end

  inst_buffer_ram #(
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_N (P_DEPTH_N)
  ) u_ram (
    .clk    (iCLOCK),
    .rst_n  (inRESET),
    .we0    (wr_amt != 2'd0),
    .waddr0 (wr_ptr),
    .wdata0 (wdata0),
    .we1    (wr_amt == 2'd2),
    .waddr1 (wr_ptr + P_DEPTH_N'(1)),
    .wdata1 (wdata1),
    .raddr0 (rd_ptr),
    .rdata0 (rdata0),
    .raddr1 (rd_ptr + P_DEPTH_N'(1)),
    .rdata1 (rdata1)
  );

  assign bus.oPREVIOUS_LOCK     = lock;
  assign bus.oNEXT_0_INST_VALID = show0;
  assign bus.oNEXT_0_MMU_FLAGS  = rdata0.flags;
  assign bus.oNEXT_0_INST       = rdata0.inst;
  assign bus.oNEXT_0_PC         = rdata0.pc;
  assign bus.oNEXT_1_INST_VALID = show1;
  assign bus.oNEXT_1_MMU_FLAGS  = rdata1.flags;
  assign bus.oNEXT_1_INST       = rdata1.inst;
  assign bus.oNEXT_1_PC         = rdata1.pc;
  assign bus.oCOUNT             = count;

endmodule
